// File: rtl/imem_loader_pkg.sv
// ============================================================================
// Module : imem_loader_pkg
// Brief  : Shared state encoding and default constants for the program loader.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_SYNC  = 3'd0,
        ST_COUNT = 3'd1,
        ST_DATA  = 3'd2,
        ST_CHECK = 3'd3,
        ST_RUN   = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

    localparam logic [7:0] C_SYNC_BYTE   = 8'hA5;
    localparam int         C_TIMEOUT_CYC = 50_000_000;

endpackage

`default_nettype wire

// File: rtl/imem_loader_idle_timer.sv
// ============================================================================
// Module : idle_timer
// Brief  : Saturating idle counter; flags expiry after TIMEOUT_CYC enabled cycles.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module idle_timer
    import imem_loader_pkg::*;
#(
    parameter int TIMEOUT_CYC = C_TIMEOUT_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int                CNT_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0]  C_LIMIT = CNT_W'(TIMEOUT_CYC);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_cnt <= '0;
        end else if (enable && !expired) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign expired = (r_cnt == C_LIMIT);

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// Module : imem_loader
// Brief  : Framed byte-stream boot loader that fills instruction RAM, then
//          releases the core.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         ADDR_W      = 5,
    parameter logic [7:0] SYNC_BYTE   = C_SYNC_BYTE,
    parameter int         TIMEOUT_CYC = C_TIMEOUT_CYC
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              imem_wren,
    output logic              cpu_run,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);

    // Count is compared at 9 bits so a 256-word memory remains expressible
    localparam logic [8:0] C_MAX_WORDS = 9'(2 ** ADDR_W);

    state_t              r_state;
    state_t              w_next;
    logic [8:0]          r_count;
    logic [ADDR_W-1:0]   r_word_idx;
    logic [1:0]          r_lane;
    logic [23:0]         r_word_lo;
    logic [7:0]          r_chk;
    logic                w_accept;
    logic                w_expired;
    logic                w_timer_en;
    logic                w_last_word;
    logic                w_take;

    assign w_accept    = rx_valid & rx_ready;
    assign w_timer_en  = (r_state == ST_COUNT) || (r_state == ST_DATA) || (r_state == ST_CHECK);
    assign w_last_word = (9'(r_word_idx) == (r_count - 9'd1));
    assign w_take      = w_accept & ~w_expired;

    idle_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_idle_timer (
        .clk     (CLOCK_50),
        .rst     (reset),
        .clear   (w_accept | ~w_timer_en),
        .enable  (w_timer_en),
        .expired (w_expired)
    );

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state <= ST_SYNC;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        rx_ready = 1'b1;
        cpu_run  = 1'b0;
        load_err = 1'b0;
        case (r_state)
            ST_SYNC: begin
                if (w_accept && rx_data == SYNC_BYTE) w_next = ST_COUNT;
            end
            ST_COUNT: begin
                if (w_expired) begin
                    w_next = ST_ERR;
                end else if (w_accept) begin
                    w_next = (rx_data == 8'd0 || {1'b0, rx_data} > C_MAX_WORDS) ? ST_ERR : ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_expired) begin
                    w_next = ST_ERR;
                end else if (w_accept && r_lane == 2'd3 && w_last_word) begin
                    w_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (w_expired) begin
                    w_next = ST_ERR;
                end else if (w_accept) begin
                    w_next = (rx_data == r_chk) ? ST_RUN : ST_ERR;
                end
            end
            ST_RUN: begin
                rx_ready = 1'b0;
                cpu_run  = 1'b1;
            end
            ST_ERR: begin
                load_err = 1'b1;
                if (w_accept && rx_data == SYNC_BYTE) w_next = ST_COUNT;
            end
            default: w_next = ST_SYNC;
        endcase
    end

    // Byte lanes, checksum and the one-cycle write strobe
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            imem_wren    <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            words_loaded <= '0;
            r_count      <= '0;
            r_word_idx   <= '0;
            r_lane       <= '0;
            r_word_lo    <= '0;
            r_chk        <= '0;
        end else begin
            imem_wren <= 1'b0;
            case (r_state)
                ST_SYNC, ST_ERR: begin
                    if (w_accept && rx_data == SYNC_BYTE) words_loaded <= '0;
                end
                ST_COUNT: begin
                    if (w_take) begin
                        r_count    <= {1'b0, rx_data};
                        r_word_idx <= '0;
                        r_lane     <= '0;
                        r_chk      <= '0;
                    end
                end
                ST_DATA: begin
                    if (w_take) begin
                        r_chk  <= r_chk ^ rx_data;
                        r_lane <= r_lane + 2'd1;
                        case (r_lane)
                            2'd0: r_word_lo[7:0]   <= rx_data;
                            2'd1: r_word_lo[15:8]  <= rx_data;
                            2'd2: r_word_lo[23:16] <= rx_data;
                            default: begin
                                imem_wren    <= 1'b1;
                                imem_addr    <= r_word_idx;
                                imem_wdata   <= {rx_data, r_word_lo};
                                words_loaded <= words_loaded + 1'b1;
                                r_word_idx   <= r_word_idx + 1'b1;
                            end
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module : tb_imem_loader
// Brief  : Scoreboard bench: expected RAM writes queued by stimulus, popped by a
//          write monitor; status outputs checked after each frame.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

    localparam int ADDR_W = 5;

    logic              CLOCK_50 = 1'b0;
    logic              reset    = 1'b1;
    logic [7:0]        rx_data  = 8'h00;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              imem_wren;
    logic              cpu_run;
    logic              load_err;
    logic [ADDR_W:0]   words_loaded;

    imem_loader #(
        .ADDR_W      (ADDR_W),
        .SYNC_BYTE   (8'hA5),
        .TIMEOUT_CYC (100)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .imem_wren    (imem_wren),
        .cpu_run      (cpu_run),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        int          addr;
        logic [31:0] data;
        int          gap;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    int          n_cmp       = 0;
    int          n_fail      = 0;
    int          cyc         = 0;
    int          last_wr_cyc = 0;
    logic [31:0] fw[64];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write monitor: every strobe must match the head of the expected queue
    always begin
        @(posedge CLOCK_50);
        #1;
        cyc++;
        if (imem_wren === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_write: addr %0d data %h, no write expected", imem_addr, imem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 64'(imem_addr), 64'(mon_e.addr));
                check("wr_data", 64'(imem_wdata), 64'(mon_e.data));
                if (mon_e.gap != 0) check("wr_gap", 64'(cyc - last_wr_cyc), 64'(mon_e.gap));
            end
            last_wr_cyc = cyc;
        end
    end

    task automatic send(input logic [7:0] b);
        @(negedge CLOCK_50);
        rx_data  = b;
        rx_valid = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLOCK_50);
            rx_valid = 1'b0;
        end
    endtask

    task automatic push_wr(input int a, input logic [31:0] d, input int g);
        wr_t e;
        e.addr = a;
        e.data = d;
        e.gap  = g;
        exp_q.push_back(e);
    endtask

    task automatic send_frame(input int n, input logic [7:0] flip);
        logic [7:0] c;
        c = 8'h00;
        send(8'hA5);
        send(8'(n));
        for (int i = 0; i < n; i++) begin
            push_wr(i, fw[i], (i == 0) ? 0 : 4);
            for (int k = 0; k < 4; k++) begin
                send(fw[i][8*k +: 8]);
                c = c ^ fw[i][8*k +: 8];
            end
        end
        send(c ^ flip);
        idle(3);
    endtask

    task automatic check_status(input string tag, input logic run, input logic err, input int wl);
        check({tag, "_cpu_run"}, 64'(cpu_run), 64'(run));
        check({tag, "_load_err"}, 64'(load_err), 64'(err));
        check({tag, "_words_loaded"}, 64'(words_loaded), 64'(wl));
    endtask

    task automatic do_reset(input string tag);
        @(negedge CLOCK_50);
        reset    = 1'b1;
        rx_valid = 1'b0;
        @(negedge CLOCK_50);
        check_status(tag, 1'b0, 1'b0, 0);
        check({tag, "_rx_ready"}, 64'(rx_ready), 64'd1);
        check({tag, "_imem_wren"}, 64'(imem_wren), 64'd0);
        check({tag, "_imem_addr"}, 64'(imem_addr), 64'd0);
        check({tag, "_imem_wdata"}, 64'(imem_wdata), 64'd0);
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        do_reset("rst0");

        // 1: single-word frame with hand-computed checksum
        push_wr(0, 32'h00100513, 0);
        send(8'hA5); send(8'h01);
        send(8'h13); send(8'h05); send(8'h10); send(8'h00);
        send(8'h06);
        idle(3);
        check_status("t1", 1'b1, 1'b0, 1);
        check("t1_rx_ready_run", 64'(rx_ready), 64'd0);
        send(8'hA5);
        idle(3);
        check_status("t1_ignored", 1'b1, 1'b0, 1);

        // 2: three words back-to-back
        do_reset("rst2");
        fw[0] = 32'h11223344; fw[1] = 32'hDEADBEEF; fw[2] = 32'h00000001;
        send_frame(3, 8'h00);
        check_status("t2", 1'b1, 1'b0, 3);

        // 3: bad checksum, then reload without reset
        do_reset("rst3");
        fw[0] = 32'hCAFEF00D;
        send_frame(1, 8'h01);
        check_status("t3_bad", 1'b0, 1'b1, 1);
        fw[0] = 32'h0BADF00D; fw[1] = 32'h12345678;
        send_frame(2, 8'h00);
        check_status("t3_good", 1'b1, 1'b0, 2);

        // 4: illegal counts, garbage bytes, then a full 32-word frame
        do_reset("rst4");
        send(8'h00); send(8'hFF); send(8'hA5); send(8'h00);
        idle(3);
        check_status("t4_n0", 1'b0, 1'b1, 0);
        send(8'hA5); send(8'd33);
        idle(3);
        check_status("t4_n33", 1'b0, 1'b1, 0);
        send(8'h00); send(8'hFF);
        for (int i = 0; i < 32; i++) fw[i] = 32'h9E3779B9 * (i + 1);
        send_frame(32, 8'h00);
        check_status("t4_n32", 1'b1, 1'b0, 32);

        // 5: timeout after two payload bytes
        do_reset("rst5");
        send(8'hA5); send(8'h01); send(8'h11); send(8'h22);
        idle(90);
        check_status("t5_before", 1'b0, 1'b0, 0);
        idle(15);
        check_status("t5_after", 1'b0, 1'b1, 0);

        // 6: reset mid-DATA, then a fresh frame
        do_reset("rst6");
        push_wr(0, 32'h04030201, 0);
        send(8'hA5); send(8'h02);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        send(8'h05); send(8'h06);
        do_reset("t6_mid");
        fw[0] = 32'hA1B2C3D4;
        send_frame(1, 8'h00);
        check_status("t6_reload", 1'b1, 1'b0, 1);

        idle(5);
        check("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
